// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor
//   Watches a VGA-style sync stream and recovers the pixel position, measures
//   the line and frame periods, and declares lock once the timing has matched
//   H_TOTAL x V_TOTAL for LOCK_FRAMES consecutive frames. While locked, any
//   deviation (wrong line/frame length or a missing sync) pulses timing_err and
//   drops back to hunting.
//
//   Ports
//     clk          pixel clock, rising edge
//     reset        asynchronous, active-high
//     hsync/vsync  active-low syncs, synchronous to clk
//     blank_b      high during active video
//     xpos/ypos    recovered active column/row of the current pixel
//     pixel_valid  xpos/ypos refer to an active pixel (blank_b delayed 1 clk)
//     locked       timing verified stable
//     timing_err   single-cycle pulse on a violation while locked
//     line_len     last hsync-to-hsync period in clocks
//     frame_lines  last vsync-to-vsync period in lines
module vga_timing_monitor #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       blank_b,
  output logic [9:0] xpos,
  output logic [9:0] ypos,
  output logic       pixel_valid,
  output logic       locked,
  output logic       timing_err,
  output logic [9:0] line_len,
  output logic [9:0] frame_lines
);

  typedef enum logic [1:0] {
    S_HUNT,
    S_MEASURE,
    S_LOCKED
  } state_t;

  state_t      state;
  logic        hs_r, vs_r, bl_r;
  logic [9:0]  hcnt, vline;
  logic [7:0]  good_cnt;
  logic        seen_hs;
  logic        frame_bad_acc;

  logic        hs_fall, vs_fall, bl_fall;
  logic        hsat, line_bad, frame_bad;
  logic [10:0] hlen;
  logic [9:0]  vline_inc, vline_eff;
  logic        h_wd, v_wd, lock_err;
  logic [7:0]  good_next;

  always_comb begin
    hs_fall   = hs_r & ~hsync;
    vs_fall   = vs_r & ~vsync;
    bl_fall   = bl_r & ~blank_b;
    hsat      = (hcnt == '1);
    hlen      = {1'b0, hcnt} + 11'd1;
    line_bad  = (hlen != 11'(H_TOTAL)) || hsat;
    vline_inc = (vline == '1) ? vline : vline + 10'd1;
    // A line ending on the same edge as vsync belongs to the closing frame.
    vline_eff = hs_fall ? vline_inc : vline;
    frame_bad = (vline_eff != 10'(V_TOTAL)) || (vline_eff == '1) ||
                frame_bad_acc || (hs_fall && line_bad);
    // Watchdogs fire on the edge where a counter reaches saturation.
    h_wd      = !hs_fall && (hcnt == 10'd1022);
    v_wd      = hs_fall && !vs_fall && (vline == 10'd1022);
    lock_err  = (hs_fall && line_bad) || (vs_fall && frame_bad) || h_wd || v_wd;
    good_next = good_cnt + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_r          <= 1'b1;
      vs_r          <= 1'b1;
      bl_r          <= 1'b1;
      hcnt          <= '0;
      vline         <= '0;
      line_len      <= '0;
      frame_lines   <= '0;
      frame_bad_acc <= 1'b0;
      seen_hs       <= 1'b0;
      pixel_valid   <= 1'b0;
      xpos          <= '0;
      ypos          <= '0;
    end else begin
      hs_r        <= hsync;
      vs_r        <= vsync;
      bl_r        <= blank_b;
      pixel_valid <= blank_b;
      xpos        <= pixel_valid ? xpos + 10'd1 : '0;

      if (vs_fall)
        ypos <= '0;
      else if (bl_fall && ypos != '1)
        ypos <= ypos + 10'd1;

      if (hs_fall) begin
        hcnt     <= '0;
        line_len <= hlen[9:0];
        seen_hs  <= 1'b1;
      end else if (!hsat) begin
        hcnt <= hcnt + 10'd1;
      end

      if (vs_fall) begin
        vline         <= '0;
        frame_lines   <= vline_eff;
        frame_bad_acc <= 1'b0;
      end else if (hs_fall) begin
        vline <= vline_inc;
        if (line_bad)
          frame_bad_acc <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_HUNT;
      good_cnt   <= '0;
      locked     <= 1'b0;
      timing_err <= 1'b0;
    end else begin
      timing_err <= 1'b0;
      case (state)
        S_HUNT: begin
          good_cnt <= '0;
          locked   <= 1'b0;
          if (vs_fall && (seen_hs || hs_fall))
            state <= S_MEASURE;
        end
        S_MEASURE: begin
          if (vs_fall) begin
            if (frame_bad) begin
              good_cnt <= '0;
            end else if (good_next == 8'(LOCK_FRAMES)) begin
              good_cnt <= good_next;
              state    <= S_LOCKED;
              locked   <= 1'b1;
            end else begin
              good_cnt <= good_next;
            end
          end
        end
        S_LOCKED: begin
          if (lock_err) begin
            timing_err <= 1'b1;
            locked     <= 1'b0;
            good_cnt   <= '0;
            state      <= S_HUNT;
          end
        end
        default: begin
          state  <= S_HUNT;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Testbench for vga_timing_monitor with a scaled-down 48x24 raster so whole
// frames fit in a short run. A behavioural model tracks sync edge timestamps
// and line counts to predict lock, error pulses and the measured periods.
module tb_vga_timing_monitor;
  localparam int H = 48, V = 24, LF = 2;
  localparam int HS_W = 6, X0 = 10, W = 32, Y0 = 4, HGT = 16, VS_L = 2;

  logic       clk = 1'b0, rst = 1'b1;
  logic       hsync = 1'b1, vsync = 1'b1, blank_b = 1'b0;
  logic [9:0] xpos, ypos, line_len, frame_lines;
  logic       pixel_valid, locked, timing_err;
  int         total = 0, bad = 0;

  vga_timing_monitor #(.H_TOTAL(H), .V_TOTAL(V), .LOCK_FRAMES(LF)) dut (
    .clk(clk), .reset(rst), .hsync(hsync), .vsync(vsync), .blank_b(blank_b),
    .xpos(xpos), .ypos(ypos), .pixel_valid(pixel_valid), .locked(locked),
    .timing_err(timing_err), .line_len(line_len), .frame_lines(frame_lines)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int   m_n, m_last_hs, m_lines, m_mode, m_good, m_exp_err = 0, m_err_n = -1;
  bit   m_seen, m_fbad, m_phs, m_pvs;
  int   e_len, e_lines;
  bit   e_locked;

  task automatic model_step();
    bit hf, vf, lbad, fb, err;
    int period, veff;
    if (rst) begin
      m_n = 0; m_last_hs = 0; m_lines = 0; m_mode = 0; m_good = 0;
      m_seen = 0; m_fbad = 0; m_phs = 1; m_pvs = 1;
      e_len = 0; e_lines = 0; e_locked = 0;
      return;
    end
    m_n++;
    hf = m_phs && !hsync;
    vf = m_pvs && !vsync;
    period = m_n - m_last_hs;
    lbad = hf && (period != H || period >= 1024);
    err = 0;
    if (m_mode == 2) begin
      if (lbad) err = 1;
      if (!hf && period == 1023) err = 1;
      if (hf && !vf && m_lines == 1022) err = 1;
    end
    if (hf) e_len = (period >= 1024) ? 0 : period;
    veff = hf ? ((m_lines < 1023) ? m_lines + 1 : 1023) : m_lines;
    if (vf) begin
      fb = (veff != V) || (veff == 1023) || m_fbad || lbad;
      e_lines = veff;
      if (m_mode == 2 && fb) err = 1;
      if (m_mode == 1) begin
        if (fb) m_good = 0; else m_good++;
        if (m_good == LF) m_mode = 2;
      end else if (m_mode == 0 && (m_seen || hf)) begin
        m_mode = 1; m_good = 0;
      end
      m_lines = 0; m_fbad = 0;
    end else if (hf) begin
      m_lines = veff;
      if (lbad) m_fbad = 1;
    end
    if (err) begin m_mode = 0; m_good = 0; m_exp_err++; m_err_n = m_n; end
    if (hf) begin m_seen = 1; m_last_hs = m_n; end
    m_phs = hsync; m_pvs = vsync;
    e_locked = (m_mode == 2);
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // ---------------- event monitor ----------------
  int dut_err_cnt = 0, dut_err_n = -1;
  bit err_wide = 0, err_with_lock = 0, prev_te = 0;
  initial forever begin
    @(negedge clk);
    if (timing_err === 1'b1) begin
      dut_err_cnt++;
      dut_err_n = m_n;
      if (locked !== 1'b0) err_with_lock = 1;
      if (prev_te) err_wide = 1;
    end
    prev_te = (timing_err === 1'b1);
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic h, input logic v, input logic b);
    @(negedge clk);
    #1;
    hsync = h; vsync = v; blank_b = b;
  endtask

  function automatic logic [2:0] pix(input int l, input int p, input bit wv);
    logic h, v, b;
    h = !(p < HS_W);
    v = !(wv && l < VS_L);
    b = (l >= Y0 && l < Y0 + HGT && p >= X0 && p < X0 + W);
    return {h, v, b};
  endfunction

  task automatic play_frame(input int nlines, input bit wv, input int bad_line, input int bad_len);
    logic [2:0] s;
    int len;
    for (int l = 0; l < nlines; l++) begin
      len = (l == bad_line) ? bad_len : H;
      for (int p = 0; p < len; p++) begin
        s = pix(l, p, wv);
        drive(s[2], s[1], s[0]);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total += 7;
    if (xpos !== 10'd0) begin bad++; $display("FAIL reset_xpos got=%0d want=0", xpos); end
    if (ypos !== 10'd0) begin bad++; $display("FAIL reset_ypos got=%0d want=0", ypos); end
    if (pixel_valid !== 1'b0) begin bad++; $display("FAIL reset_pixel_valid got=%0b want=0", pixel_valid); end
    if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%0b want=0", locked); end
    if (timing_err !== 1'b0) begin bad++; $display("FAIL reset_timing_err got=%0b want=0", timing_err); end
    if (line_len !== 10'd0) begin bad++; $display("FAIL reset_line_len got=%0d want=0", line_len); end
    if (frame_lines !== 10'd0) begin bad++; $display("FAIL reset_frame_lines got=%0d want=0", frame_lines); end
    rst = 1'b0;
  endtask

  task automatic test_lock();
    play_frame(2, 0, -1, 0);
    play_frame(V, 1, -1, 0);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_after_vs1 got=%0b want=0", locked); end
    play_frame(V, 1, -1, 0);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_after_vs2 got=%0b want=0", locked); end
    total++; if (frame_lines !== 10'(V)) begin bad++; $display("FAIL lock_frame_lines got=%0d want=%0d", frame_lines, V); end
    total++; if (line_len !== 10'(H)) begin bad++; $display("FAIL lock_line_len got=%0d want=%0d", line_len, H); end
    play_frame(V, 1, -1, 0);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_after_vs3 got=%0b want=1", locked); end
    total++; if (dut_err_cnt !== 0) begin bad++; $display("FAIL lock_no_err got=%0d want=0", dut_err_cnt); end
  endtask

  task automatic test_active_video();
    int pl = -1, pp = -1;
    bit act;
    logic [2:0] s;
    int e0 = dut_err_cnt;
    for (int l = 0; l < V; l++) begin
      for (int p = 0; p < H; p++) begin
        @(negedge clk);
        #1;
        if (pl >= 0) begin
          act = (pl >= Y0 && pl < Y0 + HGT && pp >= X0 && pp < X0 + W);
          total++;
          if (pixel_valid !== act) begin bad++; $display("FAIL pv_latency l=%0d p=%0d got=%0b want=%0b", pl, pp, pixel_valid, act); end
          if (act) begin
            total += 2;
            if (xpos !== 10'(pp - X0)) begin bad++; $display("FAIL xpos l=%0d p=%0d got=%0d want=%0d", pl, pp, xpos, pp - X0); end
            if (ypos !== 10'(pl - Y0)) begin bad++; $display("FAIL ypos l=%0d p=%0d got=%0d want=%0d", pl, pp, ypos, pl - Y0); end
          end
          if (pl == 0 && pp == 0) begin
            total++;
            if (ypos !== 10'd0) begin bad++; $display("FAIL ypos_clear_vs got=%0d want=0", ypos); end
          end
        end
        s = pix(l, p, 1);
        hsync = s[2]; vsync = s[1]; blank_b = s[0];
        pl = l; pp = p;
      end
    end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL active_locked got=%0b want=1", locked); end
    total++; if (dut_err_cnt !== e0) begin bad++; $display("FAIL active_no_err got=%0d want=%0d", dut_err_cnt, e0); end
  endtask

  task automatic test_short_line();
    int e0 = dut_err_cnt;
    play_frame(V, 1, 5, H - 1);
    total++; if (dut_err_cnt !== e0 + 1) begin bad++; $display("FAIL short_err_count got=%0d want=%0d", dut_err_cnt, e0 + 1); end
    total++; if (dut_err_n !== m_err_n) begin bad++; $display("FAIL short_err_cycle got=%0d want=%0d", dut_err_n, m_err_n); end
    total++; if (err_wide !== 1'b0) begin bad++; $display("FAIL short_err_one_cycle got=%0b want=0", err_wide); end
    total++; if (err_with_lock !== 1'b0) begin bad++; $display("FAIL short_lock_drop got=%0b want=0", err_with_lock); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL short_unlocked got=%0b want=0", locked); end
    play_frame(V, 1, -1, 0);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL short_relock_f1 got=%0b want=0", locked); end
    play_frame(V, 1, -1, 0);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL short_relock_f2 got=%0b want=0", locked); end
    play_frame(V, 1, -1, 0);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL short_relock_f3 got=%0b want=1", locked); end
  endtask

  task automatic test_watchdog();
    bit found = 0;
    for (int i = 0; i < 1200 && !found; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      if (timing_err === 1'b1) begin
        found = 1;
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL wd_locked got=%0b want=0", locked); end
        total++; if (m_n - m_last_hs !== 1023) begin bad++; $display("FAIL wd_cycle got=%0d want=1023", m_n - m_last_hs); end
      end
    end
    total++; if (!found) begin bad++; $display("FAIL wd_timeout got=0 want=1"); end
    drive(1'b1, 1'b1, 1'b0);
    total++; if (dut_err_cnt !== m_exp_err) begin bad++; $display("FAIL wd_err_count got=%0d want=%0d", dut_err_cnt, m_exp_err); end
  endtask

  task automatic test_short_frame();
    int e0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    e0 = dut_err_cnt;
    play_frame(2, 0, -1, 0);
    play_frame(V, 1, -1, 0);
    play_frame(V - 1, 1, -1, 0);
    play_frame(V, 1, -1, 0);
    total++; if (frame_lines !== 10'(V - 1)) begin bad++; $display("FAIL sf_frame_lines got=%0d want=%0d", frame_lines, V - 1); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL sf_locked_a got=%0b want=0", locked); end
    play_frame(V, 1, -1, 0);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL sf_locked_b got=%0b want=0", locked); end
    play_frame(V, 1, -1, 0);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL sf_locked_c got=%0b want=1", locked); end
    total++; if (dut_err_cnt !== e0) begin bad++; $display("FAIL sf_no_err got=%0d want=%0d", dut_err_cnt, e0); end
  endtask

  task automatic test_reset_mid_frame();
    int e0;
    play_frame(10, 1, -1, 0);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL mid_pre_locked got=%0b want=1", locked); end
    e0 = dut_err_cnt;
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    total += 4;
    if (locked !== 1'b0) begin bad++; $display("FAIL mid_locked got=%0b want=0", locked); end
    if (line_len !== 10'd0) begin bad++; $display("FAIL mid_line_len got=%0d want=0", line_len); end
    if (frame_lines !== 10'd0) begin bad++; $display("FAIL mid_frame_lines got=%0d want=0", frame_lines); end
    if (ypos !== 10'd0) begin bad++; $display("FAIL mid_ypos got=%0d want=0", ypos); end
    hsync = 1'b1; vsync = 1'b1; blank_b = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    total++; if (dut_err_cnt !== e0) begin bad++; $display("FAIL mid_no_err got=%0d want=%0d", dut_err_cnt, e0); end
    play_frame(2, 0, -1, 0);
    play_frame(V, 1, -1, 0);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL mid_relock_f1 got=%0b want=0", locked); end
    play_frame(V, 1, -1, 0);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL mid_relock_f2 got=%0b want=0", locked); end
    play_frame(V, 1, -1, 0);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL mid_relock_f3 got=%0b want=1", locked); end
  endtask

  task automatic test_random();
    int nl, bl, blen;
    for (int f = 0; f < 12; f++) begin
      nl = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? V + 1 : V - 1) : V;
      bl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, nl - 1)) : -1;
      case ($urandom_range(0, 3))
        0: blen = H - 2;
        1: blen = H - 1;
        2: blen = H + 1;
        default: blen = H + 2;
      endcase
      play_frame(nl, 1, bl, blen);
      total += 4;
      if (locked !== e_locked) begin bad++; $display("FAIL rnd_locked f=%0d got=%0b want=%0b", f, locked, e_locked); end
      if (line_len !== 10'(e_len)) begin bad++; $display("FAIL rnd_line_len f=%0d got=%0d want=%0d", f, line_len, e_len); end
      if (frame_lines !== 10'(e_lines)) begin bad++; $display("FAIL rnd_frame_lines f=%0d got=%0d want=%0d", f, frame_lines, e_lines); end
      if (dut_err_cnt !== m_exp_err) begin bad++; $display("FAIL rnd_err_count f=%0d got=%0d want=%0d", f, dut_err_cnt, m_exp_err); end
    end
    total += 2;
    if (err_wide !== 1'b0) begin bad++; $display("FAIL rnd_err_one_cycle got=%0b want=0", err_wide); end
    if (err_with_lock !== 1'b0) begin bad++; $display("FAIL rnd_lock_drop got=%0b want=0", err_with_lock); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_active_video();
    test_short_line();
    test_watchdog();
    test_short_frame();
    test_reset_mid_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
